jno_resolver: RTL and testbench

- Sequential condition resolver for the JNO (jump-if-no-overflow) instruction in the paper processor.
- Accepts a JNO issue strobe from decode and waits for the ALU overflow flag to become valid, with a bounded timeout.
- Emits a registered one-cycle 2-bit `check` vector, {taken, not_taken}, that feeds the downstream enable-OR checking stage.
- Also holds the captured jump target for the PC-update logic.

---
 rtl/paper_pkg.sv | 24 ++
 rtl/jno_wait_counter.sv | 33 +++
 rtl/jno_resolver.sv | 156 +++++++++++++++
 tb/tb_jno_resolver.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/paper_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// paper_pkg : shared types and check encodings for the paper processor
// Rev 1.0
// ---------------------------------------------------------------------------
package paper_pkg;

  typedef enum logic [1:0] {
    JNO_IDLE    = 2'd0,
    JNO_WAIT    = 2'd1,
    JNO_RESOLVE = 2'd2
  } jno_state_t;

  localparam logic [1:0] CHK_NONE      = 2'b00;
  localparam logic [1:0] CHK_NOT_TAKEN = 2'b01;
  localparam logic [1:0] CHK_TAKEN     = 2'b10;

  // JNO jumps only when no overflow was seen
  function automatic logic [1:0] chk_encode(input logic ovf);
    return ovf ? CHK_NOT_TAKEN : CHK_TAKEN;
  endfunction

endpackage
`default_nettype wire

// File: rtl/jno_wait_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// jno_wait_counter : saturating wait counter, flags the last allowed cycle
// Rev 1.0
// ---------------------------------------------------------------------------
module jno_wait_counter #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int              CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_count;

  assign expire = enable && (r_count == C_LAST);

  // Holds at the last value instead of wrapping
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (enable && !expire) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/jno_resolver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// jno_resolver : JNO condition resolver with bounded flag wait.
// Optional one-deep pending slot: JNO_RESOLVER_QUEUE_EN.   Rev 1.0
// ---------------------------------------------------------------------------
module jno_resolver
  import paper_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              jno_req,
  input  logic [ADDR_W-1:0] target,
  input  logic              flag_valid,
  input  logic              overflow,
  output logic [1:0]        check,
  output logic [ADDR_W-1:0] target_q,
  output logic              busy,
  output logic              timeout_err
);

  jno_state_t        r_state;
  jno_state_t        w_next;
  logic [1:0]        r_check;
  logic [ADDR_W-1:0] r_target_q;
  logic              r_timeout_err;

  logic              w_accept;
  logic [ADDR_W-1:0] w_accept_tgt;
  logic              w_resolve;
  logic              w_res_ovf;
  logic              w_force;
  logic              w_expire;

`ifdef JNO_RESOLVER_QUEUE_EN
  logic              r_pend_valid;
  logic [ADDR_W-1:0] r_pend_target;
  logic              w_pend_set;
  logic              w_pend_clr;
`endif

  jno_wait_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (r_state != JNO_WAIT),
    .enable (r_state == JNO_WAIT),
    .expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= JNO_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_accept     = 1'b0;
    w_accept_tgt = target;
    w_resolve    = 1'b0;
    w_res_ovf    = 1'b0;
    w_force      = 1'b0;
`ifdef JNO_RESOLVER_QUEUE_EN
    w_pend_set   = 1'b0;
    w_pend_clr   = 1'b0;
`endif
    case (r_state)
      JNO_IDLE: begin
        w_accept = jno_req;
      end
      JNO_WAIT: begin
        if (flag_valid) begin
          w_next    = JNO_RESOLVE;
          w_resolve = 1'b1;
          w_res_ovf = overflow;
        end else if (w_expire) begin
          w_next    = JNO_RESOLVE;
          w_resolve = 1'b1;
          w_res_ovf = 1'b1;
          w_force   = 1'b1;
        end
`ifdef JNO_RESOLVER_QUEUE_EN
        w_pend_set = jno_req && !r_pend_valid;
`endif
      end
      JNO_RESOLVE: begin
        w_next = JNO_IDLE;
`ifdef JNO_RESOLVER_QUEUE_EN
        // A stored request outranks a new one; a new one with a full slot is lost
        if (r_pend_valid) begin
          w_accept     = 1'b1;
          w_accept_tgt = r_pend_target;
          w_pend_clr   = 1'b1;
        end else begin
          w_accept = jno_req;
        end
`endif
      end
      default: w_next = JNO_IDLE;
    endcase

    if (w_accept) begin
      if (flag_valid) begin
        w_next    = JNO_RESOLVE;
        w_resolve = 1'b1;
        w_res_ovf = overflow;
      end else begin
        w_next = JNO_WAIT;
      end
    end
  end

  // check is loaded on the edge into RESOLVE so it is live exactly in that state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_check       <= CHK_NONE;
      r_target_q    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_check <= w_resolve ? chk_encode(w_res_ovf) : CHK_NONE;
      if (w_accept) begin
        r_target_q <= w_accept_tgt;
      end
      if (w_force) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

`ifdef JNO_RESOLVER_QUEUE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_valid  <= 1'b0;
      r_pend_target <= '0;
    end else if (w_pend_clr) begin
      r_pend_valid <= 1'b0;
    end else if (w_pend_set) begin
      r_pend_valid  <= 1'b1;
      r_pend_target <= target;
    end
  end
`endif

  assign check       = r_check;
  assign target_q    = r_target_q;
  assign busy        = (r_state != JNO_IDLE);
  assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_jno_resolver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_jno_resolver : vector table, corner sequences and random run vs model.
// Honours JNO_RESOLVER_QUEUE_EN.   Rev 1.0
// ---------------------------------------------------------------------------
module tb_jno_resolver;

  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              jno_req = 1'b0;
  logic [ADDR_W-1:0] target = '0;
  logic              flag_valid = 1'b0;
  logic              overflow = 1'b0;
  logic [1:0]        check;
  logic [ADDR_W-1:0] target_q;
  logic              busy;
  logic              timeout_err;

  int n_checks = 0;
  int n_err    = 0;

  jno_resolver #(
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .jno_req     (jno_req),
    .target      (target),
    .flag_valid  (flag_valid),
    .overflow    (overflow),
    .check       (check),
    .target_q    (target_q),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // Reference model: an outstanding job waiting for its flag, plus the
  // one-cycle result window and an optional backlog of stored targets.
  bit         m_waiting;
  bit         m_resolving;
  bit         m_err;
  int         m_waited;
  logic [1:0] m_check;
  logic [7:0] m_tq;
  logic [7:0] m_pend[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_waiting   = 1'b0;
    m_resolving = 1'b0;
    m_err       = 1'b0;
    m_waited    = 0;
    m_check     = 2'b00;
    m_tq        = 8'h00;
    m_pend.delete();
  endtask

  task automatic model_step(input bit rq, input logic [7:0] tg, input bit fv, input bit ov);
    bit         accept;
    logic [7:0] acc_t;
    bit         res;
    bit         res_ovf;
    accept  = 1'b0;
    acc_t   = tg;
    res     = 1'b0;
    res_ovf = 1'b0;
    if (m_resolving) begin
      m_resolving = 1'b0;
`ifdef JNO_RESOLVER_QUEUE_EN
      if (m_pend.size() > 0) begin
        accept = 1'b1;
        acc_t  = m_pend.pop_front();
      end else if (rq) begin
        accept = 1'b1;
      end
`endif
    end else if (m_waiting) begin
`ifdef JNO_RESOLVER_QUEUE_EN
      if (rq && m_pend.size() == 0) m_pend.push_back(tg);
`endif
      if (fv) begin
        m_waiting = 1'b0;
        res       = 1'b1;
        res_ovf   = ov;
      end else if (m_waited + 1 >= TIMEOUT) begin
        m_waiting = 1'b0;
        res       = 1'b1;
        res_ovf   = 1'b1;
        m_err     = 1'b1;
      end else begin
        m_waited++;
      end
    end else if (rq) begin
      accept = 1'b1;
    end
    if (accept) begin
      m_tq = acc_t;
      if (fv) begin
        res     = 1'b1;
        res_ovf = ov;
      end else begin
        m_waiting = 1'b1;
        m_waited  = 0;
      end
    end
    m_resolving = res;
    m_check     = !res ? 2'b00 : (res_ovf ? 2'b01 : 2'b10);
  endtask

  task automatic cycle(input bit rq, input logic [7:0] tg, input bit fv, input bit ov, input bit rs);
    jno_req    = rq;
    target     = tg;
    flag_valid = fv;
    overflow   = ov;
    reset      = rs;
    @(posedge clk);
    if (rs) model_reset();
    else    model_step(rq, tg, fv, ov);
    #1;
    chk("model.check", 32'(check), 32'(m_check));
    chk("model.target_q", 32'(target_q), 32'(m_tq));
    chk("model.busy", 32'(busy), 32'(m_waiting || m_resolving));
    chk("model.timeout_err", 32'(timeout_err), 32'(m_err));
  endtask

  typedef struct {
    bit         rq;
    logic [7:0] tg;
    bit         fv;
    bit         ov;
    bit         rs;
    logic [1:0] e_chk;
    logic [7:0] e_tq;
    bit         e_busy;
    bit         e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rq, logic [7:0] tg, bit fv, bit ov, bit rs,
                              logic [1:0] e_chk, logic [7:0] e_tq, bit e_busy, bit e_err);
    vec_t v;
    v.rq = rq; v.tg = tg; v.fv = fv; v.ov = ov; v.rs = rs;
    v.e_chk = e_chk; v.e_tq = e_tq; v.e_busy = e_busy; v.e_err = e_err;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   rq, fv, ov, rs;
    int   fv_pct;

    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 2'b00, 8'h00, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 2'b00, 8'h00, 0, 0));
    vecs.push_back(mk(1, 8'h3C, 1, 0, 0, 2'b10, 8'h3C, 1, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 2'b00, 8'h3C, 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 1, 0, 2'b00, 8'h3C, 0, 0));
    vecs.push_back(mk(1, 8'h55, 0, 0, 0, 2'b00, 8'h55, 1, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 2'b00, 8'h55, 1, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 2'b00, 8'h55, 1, 0));
    vecs.push_back(mk(0, 8'h00, 1, 1, 0, 2'b01, 8'h55, 1, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 2'b00, 8'h55, 0, 0));
    vecs.push_back(mk(1, 8'h66, 1, 1, 0, 2'b01, 8'h66, 1, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 2'b00, 8'h66, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].rq, vecs[i].tg, vecs[i].fv, vecs[i].ov, vecs[i].rs);
      chk($sformatf("vec%0d.check", i), 32'(check), 32'(vecs[i].e_chk));
      chk($sformatf("vec%0d.target_q", i), 32'(target_q), 32'(vecs[i].e_tq));
      chk($sformatf("vec%0d.busy", i), 32'(busy), 32'(vecs[i].e_busy));
      chk($sformatf("vec%0d.timeout_err", i), 32'(timeout_err), 32'(vecs[i].e_err));
    end

    // Flag arriving in the expire cycle resolves normally
    cycle(0, 8'h00, 0, 0, 1);
    cycle(1, 8'h77, 0, 0, 0);
    for (int k = 1; k < TIMEOUT; k++) begin
      cycle(0, 8'h00, 0, 0, 0);
      chk("expire_flag.wait_check", 32'(check), 32'd0);
    end
    cycle(0, 8'h00, 1, 0, 0);
    chk("expire_flag.check", 32'(check), 32'b10);
    chk("expire_flag.err", 32'(timeout_err), 32'd0);

    // Forced resolution after TIMEOUT wait cycles
    cycle(0, 8'h00, 0, 0, 1);
    cycle(1, 8'h88, 0, 0, 0);
    for (int k = 1; k < TIMEOUT; k++) begin
      cycle(0, 8'h00, 0, 0, 0);
      chk("timeout.wait_check", 32'(check), 32'd0);
      chk("timeout.wait_busy", 32'(busy), 32'd1);
    end
    cycle(0, 8'h00, 0, 0, 0);
    chk("timeout.check", 32'(check), 32'b01);
    chk("timeout.err", 32'(timeout_err), 32'd1);
    cycle(0, 8'h00, 0, 0, 0);
    chk("timeout.after_busy", 32'(busy), 32'd0);
    cycle(1, 8'h99, 1, 0, 0);
    chk("timeout.clean_check", 32'(check), 32'b10);
    chk("timeout.sticky_err", 32'(timeout_err), 32'd1);
    cycle(0, 8'h00, 0, 0, 0);

    // Reset in WAIT drops the job
    cycle(1, 8'hAA, 0, 0, 0);
    cycle(0, 8'h00, 0, 0, 0);
    cycle(0, 8'h00, 0, 0, 1);
    chk("rst_wait.busy", 32'(busy), 32'd0);
    chk("rst_wait.check", 32'(check), 32'd0);
    chk("rst_wait.target_q", 32'(target_q), 32'd0);
    cycle(0, 8'h00, 1, 0, 0);
    chk("rst_wait.flag_check", 32'(check), 32'd0);
    cycle(0, 8'h00, 0, 0, 0);
    chk("rst_wait.idle_check", 32'(check), 32'd0);

    // Reset cutting a RESOLVE pulse
    cycle(1, 8'hBB, 1, 0, 0);
    chk("rst_res.pulse", 32'(check), 32'b10);
    cycle(0, 8'h00, 0, 0, 1);
    chk("rst_res.check", 32'(check), 32'd0);
    cycle(0, 8'h00, 0, 0, 0);

`ifdef JNO_RESOLVER_QUEUE_EN
    cycle(1, 8'h10, 1, 0, 0);
    chk("q.first_check", 32'(check), 32'b10);
    cycle(1, 8'h20, 1, 0, 0);
    chk("q.second_check", 32'(check), 32'b10);
    chk("q.second_tq", 32'(target_q), 32'h20);
    cycle(0, 8'h00, 0, 0, 0);
    chk("q.idle_busy", 32'(busy), 32'd0);
    cycle(1, 8'h30, 0, 0, 0);
    cycle(1, 8'h40, 0, 0, 0);
    cycle(1, 8'h50, 0, 0, 0);
    cycle(0, 8'h00, 1, 1, 0);
    chk("q.res_check", 32'(check), 32'b01);
    chk("q.res_tq", 32'(target_q), 32'h30);
    cycle(0, 8'h00, 0, 0, 0);
    chk("q.handoff_busy", 32'(busy), 32'd1);
    chk("q.handoff_tq", 32'(target_q), 32'h40);
    cycle(0, 8'h00, 1, 0, 0);
    chk("q.pend_check", 32'(check), 32'b10);
    cycle(0, 8'h00, 0, 0, 0);
    chk("q.drop_busy", 32'(busy), 32'd0);
    chk("q.drop_tq", 32'(target_q), 32'h40);
`else
    cycle(1, 8'hA0, 0, 0, 0);
    cycle(1, 8'hB0, 0, 0, 0);
    chk("drop.wait_tq", 32'(target_q), 32'hA0);
    cycle(0, 8'h00, 1, 0, 0);
    chk("drop.check", 32'(check), 32'b10);
    cycle(1, 8'hC0, 1, 0, 0);
    chk("drop.res_check", 32'(check), 32'd0);
    chk("drop.res_busy", 32'(busy), 32'd0);
    chk("drop.res_tq", 32'(target_q), 32'hA0);
`endif

    for (int i = 0; i < 3000; i++) begin
      fv_pct = (i < 1500) ? 30 : 4;
      rq = ($urandom_range(0, 99) < 35);
      fv = ($urandom_range(0, 99) < fv_pct);
      ov = $urandom_range(0, 1) == 1;
      rs = ($urandom_range(0, 299) == 0);
      cycle(rq, 8'($urandom), fv, ov, rs);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
